// File: rtl/seg_display_scanner.sv
`default_nettype none
// ============================================================================
// Module   : seg_display_scanner
// Brief    : Time-multiplexed seven-segment scanner with frame-aligned shadow
//            load, blanking, decimal points and leading-zero suppression.
//            Optional macro SEG_SCAN_GHOST_GUARD_EN darkens tick 0 of each slot.
// Revision : 1.0 - initial release
// ============================================================================
module seg_display_scanner #(
    parameter int unsigned DIGITS          = 4,
    parameter int unsigned TICKS_PER_DIGIT = 500,
    parameter int unsigned SEG_ACTIVE_LOW  = 1,
    parameter int unsigned SEL_ACTIVE_LOW  = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp_mask,
    input  logic [DIGITS-1:0]     blank_mask,
    input  logic                  lz_suppress,
    input  logic                  load,
    output logic                  update_pending,
    output logic                  frame_start,
    output logic [DIGITS-1:0]     digit_sel,
    output logic [7:0]            display
);

    localparam int unsigned c_TICK_W = $clog2(TICKS_PER_DIGIT);
    localparam int unsigned c_IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [c_TICK_W-1:0] c_TICK_LAST = c_TICK_W'(TICKS_PER_DIGIT - 1);
    localparam logic [c_IDX_W-1:0]  c_IDX_LAST  = c_IDX_W'(DIGITS - 1);

    localparam logic              c_SEG_INV = (SEG_ACTIVE_LOW != 0);
    localparam logic              c_SEL_INV = (SEL_ACTIVE_LOW != 0);
    localparam logic [7:0]        c_DISP_OFF = {8{c_SEG_INV}};
    localparam logic [DIGITS-1:0] c_SEL_OFF  = {DIGITS{c_SEL_INV}};

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [c_TICK_W-1:0]  tick_q,  tick_d;
    logic [c_IDX_W-1:0]   idx_q,   idx_d;

    logic [4*DIGITS-1:0]  sh_value_q, sh_value_d;
    logic [DIGITS-1:0]    sh_dp_q,    sh_dp_d;
    logic [DIGITS-1:0]    sh_blank_q, sh_blank_d;
    logic                 sh_lz_q,    sh_lz_d;
    logic                 pend_q,     pend_d;

    logic [4*DIGITS-1:0]  act_value_q, act_value_d;
    logic [DIGITS-1:0]    act_dp_q,    act_dp_d;
    logic [DIGITS-1:0]    act_blank_q, act_blank_d;
    logic                 act_lz_q,    act_lz_d;

    logic                 frame_start_q, frame_start_d;
    logic [DIGITS-1:0]    sel_q,  sel_d;
    logic [7:0]           disp_q, disp_d;

    logic w_term;
    logic w_frame_end;

    assign w_term      = (tick_q == c_TICK_LAST);
    assign w_frame_end = w_term && (idx_q == c_IDX_LAST);

    // ------------------------------------------------------------------
    // Scan counters and shadow/active commit
    // ------------------------------------------------------------------
    always_comb begin
        tick_d      = w_term ? '0 : tick_q + c_TICK_W'(1);
        idx_d       = idx_q;
        sh_value_d  = sh_value_q;
        sh_dp_d     = sh_dp_q;
        sh_blank_d  = sh_blank_q;
        sh_lz_d     = sh_lz_q;
        pend_d      = pend_q;
        act_value_d = act_value_q;
        act_dp_d    = act_dp_q;
        act_blank_d = act_blank_q;
        act_lz_d    = act_lz_q;

        if (w_term) begin
            idx_d = (idx_q == c_IDX_LAST) ? '0 : idx_q + c_IDX_W'(1);
        end

        // A load landing on the boundary skips the shadow so it is never late.
        if (w_frame_end) begin
            if (load) begin
                act_value_d = value;
                act_dp_d    = dp_mask;
                act_blank_d = blank_mask;
                act_lz_d    = lz_suppress;
            end else if (pend_q) begin
                act_value_d = sh_value_q;
                act_dp_d    = sh_dp_q;
                act_blank_d = sh_blank_q;
                act_lz_d    = sh_lz_q;
            end
            pend_d = 1'b0;
        end else if (load) begin
            sh_value_d = value;
            sh_dp_d    = dp_mask;
            sh_blank_d = blank_mask;
            sh_lz_d    = lz_suppress;
            pend_d     = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Rendering
    // ------------------------------------------------------------------
    function automatic logic [6:0] f_glyph(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0: seg = 7'h3F;
            4'h1: seg = 7'h06;
            4'h2: seg = 7'h5B;
            4'h3: seg = 7'h4F;
            4'h4: seg = 7'h66;
            4'h5: seg = 7'h6D;
            4'h6: seg = 7'h7D;
            4'h7: seg = 7'h07;
            4'h8: seg = 7'h7F;
            4'h9: seg = 7'h6F;
            4'hA: seg = 7'h77;
            4'hB: seg = 7'h7C;
            4'hC: seg = 7'h39;
            4'hD: seg = 7'h5E;
            4'hE: seg = 7'h79;
            default: seg = 7'h71;
        endcase
        return seg;
    endfunction

    logic [3:0]        w_nib [DIGITS];
    logic [DIGITS:0]   w_hi_zero;
    logic [DIGITS-1:0] w_lz_dark;

    assign w_hi_zero[DIGITS] = 1'b1;

    // w_hi_zero[i] is set when nibble i and every nibble above it are zero.
    generate
        for (genvar g = 0; g < DIGITS; g++) begin : g_nib
            assign w_nib[g]     = act_value_q[4*g +: 4];
            assign w_hi_zero[g] = w_hi_zero[g+1] && (w_nib[g] == 4'h0);
            if (g == 0) begin : g_lsd
                assign w_lz_dark[g] = 1'b0;
            end else begin : g_upper
                assign w_lz_dark[g] = act_lz_q && w_hi_zero[g];
            end
        end
    endgenerate

    logic       w_ghost;
    logic       w_dark;
    logic [6:0] w_seg;
    logic       w_dp;
    logic [DIGITS-1:0] w_sel;

`ifdef SEG_SCAN_GHOST_GUARD_EN
    assign w_ghost = (tick_q == '0);
`else
    assign w_ghost = 1'b0;
`endif

    always_comb begin
        w_dark = act_blank_q[idx_q] || w_lz_dark[idx_q];
        w_seg  = w_dark ? 7'h00 : f_glyph(w_nib[idx_q]);
        w_dp   = act_dp_q[idx_q] && !act_blank_q[idx_q];
        w_sel  = '0;
        for (int i = 0; i < DIGITS; i++) begin
            w_sel[i] = (idx_q == c_IDX_W'(i));
        end
        if (w_ghost) begin
            w_seg = 7'h00;
            w_dp  = 1'b0;
            w_sel = '0;
        end
        disp_d        = {w_dp, w_seg} ^ c_DISP_OFF;
        sel_d         = w_sel ^ c_SEL_OFF;
        frame_start_d = (tick_q == '0) && (idx_q == '0);
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            tick_q        <= '0;
            idx_q         <= '0;
            sh_value_q    <= '0;
            sh_dp_q       <= '0;
            sh_blank_q    <= '0;
            sh_lz_q       <= 1'b0;
            pend_q        <= 1'b0;
            act_value_q   <= '0;
            act_dp_q      <= '0;
            act_blank_q   <= '0;
            act_lz_q      <= 1'b0;
            frame_start_q <= 1'b0;
            sel_q         <= c_SEL_OFF;
            disp_q        <= c_DISP_OFF;
        end else begin
            tick_q        <= tick_d;
            idx_q         <= idx_d;
            sh_value_q    <= sh_value_d;
            sh_dp_q       <= sh_dp_d;
            sh_blank_q    <= sh_blank_d;
            sh_lz_q       <= sh_lz_d;
            pend_q        <= pend_d;
            act_value_q   <= act_value_d;
            act_dp_q      <= act_dp_d;
            act_blank_q   <= act_blank_d;
            act_lz_q      <= act_lz_d;
            frame_start_q <= frame_start_d;
            sel_q         <= sel_d;
            disp_q        <= disp_d;
        end
    end

    assign update_pending = pend_q;
    assign frame_start    = frame_start_q;
    assign digit_sel      = sel_q;
    assign display        = disp_q;

endmodule
`default_nettype wire
